// File: rtl/byte_serial_adder.sv
// Byte-serial adder: one cpa8 slice walks NBYTES operand bytes, with the carry
// held in a register between bytes, so the critical path is one 8-bit ripple.

module cpa8 (
  input  logic [7:0] num1,
  input  logic [7:0] num2,
  input  logic       cin,
  output logic [7:0] out,
  output logic       cout
);
  assign {cout, out} = {1'b0, num1} + {1'b0, num2} + {8'd0, cin};
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4,
  localparam int WIDTH = 8 * NBYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rs_q, rs_d;

  logic [7:0] s8;
  logic       c8;

  cpa8 u_cpa8 (
    .num1 (ra_q[8*idx_q +: 8]),
    .num2 (rb_q[8*idx_q +: 8]),
    .cin  (cy_q),
    .out  (s8),
    .cout (c8)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cy_q   <= 1'b0;
      cout_q <= 1'b0;
      ra_q   <= '0;
      rb_q   <= '0;
      rs_q   <= '0;
    end else begin
      idx_q  <= idx_d;
      cy_q   <= cy_d;
      cout_q <= cout_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      rs_q   <= rs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    cout_d    = cout_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rs_d      = rs_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ra_d    = a;
          rb_d    = b;
          cy_d    = cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        rs_d[8*idx_q +: 8] = s8;
        cy_d               = c8;
        if (idx_q == LAST) begin
          cout_d  = c8;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // A pending in_valid is deliberately not taken here; IDLE takes it next cycle.
        if (out_ready) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = rs_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Bench for byte_serial_adder: directed table and corner sequences on a 4-byte
// instance, then randomized back-to-back traffic on 4-byte and 1-byte instances.

module tb_byte_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid4 = 0, in_ready4, cin4 = 0, out_valid4, out_ready4 = 0, cout4;
  logic [31:0] a4 = 0, b4 = 0, sum4;
  logic        in_valid1 = 0, in_ready1, cin1 = 0, out_valid1, out_ready1 = 0, cout1;
  logic [7:0]  a1 = 0, b1 = 0, sum1;

  byte_serial_adder #(.NBYTES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4));
  byte_serial_adder #(.NBYTES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1));

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic c,
                     output logic [31:0] s, output logic co, output int lat);
    int w = 0;
    while (!in_ready4 && w < 20) begin tick(); w++; end
    a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin tick(); lat++; end
    s = sum4; co = cout4;
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] es;
    logic        ec;
  } vec_t;

  vec_t vt[6];
  logic [31:0] s;
  logic        co;
  int          lat;

  // random-phase state
  logic [32:0] q4[$];
  logic [8:0]  q1[$];
  int sent4, sent1, got4, got1, cyc;
  logic fire4, fire1, ret4, ret1;
  logic [32:0] exp4;
  logic [8:0]  exp1;

  initial begin
    vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vt[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vt[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vt[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};

    #1;
    chk("reset out_valid", out_valid4, 0);
    chk("reset in_ready", in_ready4, 1);
    chk("reset sum", sum4, 0);
    chk("reset cout", cout4, 0);
    chk("reset1 in_ready", in_ready1, 1);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      op4(vt[i].a, vt[i].b, vt[i].cin, s, co, lat);
      chk($sformatf("vec%0d latency", i), lat, 4);
      chk($sformatf("vec%0d sum", i), s, vt[i].es);
      chk($sformatf("vec%0d cout", i), co, vt[i].ec);
    end

    // backpressure in DONE
    a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 0; in_valid4 = 1;
    tick(); in_valid4 = 0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", out_valid4, 1);
      chk("bp sum", sum4, 32'h23456789);
      chk("bp in_ready", in_ready4, 0);
      tick();
    end
    out_ready4 = 1; tick(); out_ready4 = 0;
    chk("bp retire in_ready", in_ready4, 1);
    chk("bp retire out_valid", out_valid4, 0);

    // operands churn during ADD; in_valid also held into DONE with out_ready
    a4 = 32'h01020304; b4 = 32'h10203040; cin4 = 1; in_valid4 = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("churn in_ready", in_ready4, 0);
      a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom);
      tick();
    end
    chk("churn out_valid", out_valid4, 1);
    chk("churn sum", sum4, 32'h11223345);
    chk("churn cout", cout4, 0);
    out_ready4 = 1; tick();
    chk("simul retire in_ready", in_ready4, 1);
    chk("simul retire out_valid", out_valid4, 0);
    in_valid4 = 0; out_ready4 = 0;
    tick();

    // async reset in the middle of an ADD
    a4 = 32'hFFFFFFFF; b4 = 32'h1; cin4 = 0; in_valid4 = 1;
    tick(); in_valid4 = 0;
    tick(); tick();
    rst = 1; #1;
    chk("midrst out_valid", out_valid4, 0);
    chk("midrst in_ready", in_ready4, 1);
    tick(); rst = 0;
    op4(32'h1, 32'h1, 1'b0, s, co, lat);
    chk("postrst sum", s, 32'h2);
    chk("postrst cout", co, 0);
    chk("postrst latency", lat, 4);

    // random back-to-back traffic on both instances
    sent4 = 0; sent1 = 0; got4 = 0; got1 = 0; cyc = 0;
    while ((got4 < 500 || got1 < 500) && cyc < 40000) begin
      if (!in_valid4 && sent4 < 500 && $urandom_range(3) != 0) begin
        in_valid4 = 1; a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom);
      end
      if (!in_valid1 && sent1 < 500 && $urandom_range(3) != 0) begin
        in_valid1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
      end
      out_ready4 = ($urandom_range(2) != 0);
      out_ready1 = ($urandom_range(2) != 0);
      fire4 = in_valid4 && in_ready4;
      fire1 = in_valid1 && in_ready1;
      ret4  = out_valid4 && out_ready4;
      ret1  = out_valid1 && out_ready1;
      if (ret4) begin
        got4++;
        exp4 = (q4.size() != 0) ? q4.pop_front() : 33'h1_DEAD_BEEF;
        chk("rand4 result", {cout4, sum4}, exp4);
      end
      if (ret1) begin
        got1++;
        exp1 = (q1.size() != 0) ? q1.pop_front() : 9'h1FF;
        chk("rand1 result", {cout1, sum1}, exp1);
      end
      if (fire4) begin
        q4.push_back({1'b0, a4} + {1'b0, b4} + 33'(cin4));
        sent4++; in_valid4 = 0;
      end
      if (fire1) begin
        q1.push_back({1'b0, a1} + {1'b0, b1} + 9'(cin1));
        sent1++; in_valid1 = 0;
      end
      // in_valid drop must land after the edge that accepted it
      if (fire4) begin in_valid4 = 1; end
      if (fire1) begin in_valid1 = 1; end
      tick();
      if (fire4) in_valid4 = 0;
      if (fire1) in_valid1 = 0;
      cyc++;
    end
    chk("rand4 count", got4, 500);
    chk("rand1 count", got1, 500);
    chk("rand4 leftover", q4.size(), 0);
    chk("rand1 leftover", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
